// File: rtl/pipe_pkg.sv
// Shared types and constants for the rv32i pipeline stage registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int PIPE_W = 32;
    localparam logic [PIPE_W-1:0] PIPE_NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  fun3;
        logic [6:0]  fun7;
        logic [4:0]  rd;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
    } id_ex_t;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  fun3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] store_val;
    } ex_mem_t;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [31:0] data;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_q
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_q;

    // Counter register: clear, saturating increment, or hold.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_q <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            r_q <= {CNT_W{1'b0}};
        end else if (i_inc && (r_q != CNT_MAX)) begin
            r_q <= r_q + CNT_ONE;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register: valid/ready handshake, optional 2-entry skid,
// flush to a NOP bubble and a saturating back-pressure counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int                SKID      = 1,
    parameter int                CNT_W     = 16
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_flush,
    input  logic              i_cnt_clr,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    logic              w_valid;
    logic              w_ready;
    logic [DATA_W-1:0] w_data;

    generate
        if (SKID != 0) begin : g_skid
            state_t            r_state;
            state_t            w_state_nxt;
            logic [DATA_W-1:0] r_m;
            logic [DATA_W-1:0] r_s;
            logic [DATA_W-1:0] w_m_nxt;
            logic [DATA_W-1:0] w_s_nxt;
            logic              r_valid;
            logic              r_ready;
            logic              w_in;
            logic              w_out;

            assign w_in  = i_valid & r_ready;
            assign w_out = r_valid & i_ready;

            // Next-state/payload selection; flush overrides every handshake.
            always_comb begin
                w_state_nxt = r_state;
                w_m_nxt     = r_m;
                w_s_nxt     = r_s;
                if (i_flush) begin
                    w_state_nxt = EMPTY;
                    w_m_nxt     = NOP_VALUE;
                    w_s_nxt     = NOP_VALUE;
                end else begin
                    case (r_state)
                        EMPTY: begin
                            if (w_in) begin
                                w_state_nxt = BUSY;
                                w_m_nxt     = i_data;
                            end else begin
                                w_state_nxt = EMPTY;
                            end
                        end
                        BUSY: begin
                            if (w_in && w_out) begin
                                w_m_nxt = i_data;
                            end else if (w_in) begin
                                w_state_nxt = FULL;
                                w_s_nxt     = i_data;
                            end else if (w_out) begin
                                w_state_nxt = EMPTY;
                                w_m_nxt     = NOP_VALUE;
                            end else begin
                                w_state_nxt = BUSY;
                            end
                        end
                        FULL: begin
                            // The skid entry is always younger than M, so it drains second.
                            if (w_out) begin
                                w_state_nxt = BUSY;
                                w_m_nxt     = r_s;
                                w_s_nxt     = NOP_VALUE;
                            end else begin
                                w_state_nxt = FULL;
                            end
                        end
                        default: begin
                            w_state_nxt = EMPTY;
                            w_m_nxt     = NOP_VALUE;
                            w_s_nxt     = NOP_VALUE;
                        end
                    endcase
                end
            end

            // State, payload and decoded handshake flags.
            always_ff @(posedge clock or negedge rst) begin
                if (!rst) begin
                    r_state <= EMPTY;
                    r_m     <= NOP_VALUE;
                    r_s     <= NOP_VALUE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end else begin
                    r_state <= w_state_nxt;
                    r_m     <= w_m_nxt;
                    r_s     <= w_s_nxt;
                    r_valid <= (w_state_nxt != EMPTY);
                    r_ready <= (w_state_nxt != FULL);
                end
            end

            assign w_valid = r_valid;
            assign w_ready = r_ready;
            assign w_data  = r_m;
        end else begin : g_single
            logic [DATA_W-1:0] r_m;
            logic              r_valid;
            logic              w_in;
            logic              w_out;

            assign w_ready = ~r_valid | i_ready;
            assign w_in    = i_valid & w_ready;
            assign w_out   = r_valid & i_ready;

            // Single holding register; flush first, then load, then drain.
            always_ff @(posedge clock or negedge rst) begin
                if (!rst) begin
                    r_m     <= NOP_VALUE;
                    r_valid <= 1'b0;
                end else if (i_flush) begin
                    r_m     <= NOP_VALUE;
                    r_valid <= 1'b0;
                end else if (w_in) begin
                    r_m     <= i_data;
                    r_valid <= 1'b1;
                end else if (w_out) begin
                    r_m     <= NOP_VALUE;
                    r_valid <= 1'b0;
                end else begin
                    r_m     <= r_m;
                    r_valid <= r_valid;
                end
            end

            assign w_valid = r_valid;
            assign w_data  = r_m;
        end
    endgenerate

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clock (clock),
        .rst   (rst),
        .i_inc (w_valid & ~i_ready),
        .i_clr (i_cnt_clr),
        .o_q   (o_stall_cnt)
    );

    assign o_valid = w_valid;
    assign o_ready = w_ready;
    assign o_data  = w_data;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench: a skid stage (CNT_W=4) and a single-register stage side by side.
module tb_pipe_stage_skid;

    logic        clock = 1'b0;
    logic        rst   = 1'b0;

    logic        s_valid, s_ready_o, s_ovalid, s_iready, s_flush, s_clr;
    logic [31:0] s_idata, s_odata;
    logic [3:0]  s_cnt;

    logic        n_valid, n_ready_o, n_ovalid, n_iready, n_flush, n_clr;
    logic [31:0] n_idata, n_odata;
    logic [15:0] n_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] sq[$];
    logic [31:0] nq[$];

    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        fl;
        logic        clr;
        logic        ev;
        logic        erdy;
        logic [31:0] ed;
        logic [3:0]  ec;
    } vec_t;

    vec_t vecs [0:17];

    always #5 clock = ~clock;

    pipe_stage_skid #(.DATA_W(32), .SKID(1), .CNT_W(4)) u_skid (
        .clock(clock), .rst(rst),
        .i_valid(s_valid), .o_ready(s_ready_o), .i_data(s_idata),
        .o_valid(s_ovalid), .i_ready(s_iready), .o_data(s_odata),
        .i_flush(s_flush), .i_cnt_clr(s_clr), .o_stall_cnt(s_cnt)
    );

    pipe_stage_skid #(.DATA_W(32), .SKID(0), .CNT_W(16)) u_noskid (
        .clock(clock), .rst(rst),
        .i_valid(n_valid), .o_ready(n_ready_o), .i_data(n_idata),
        .o_valid(n_ovalid), .i_ready(n_iready), .o_data(n_odata),
        .i_flush(n_flush), .i_cnt_clr(n_clr), .o_stall_cnt(n_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] d, input logic r,
                                input logic fl, input logic clr, input logic ev,
                                input logic erdy, input logic [31:0] ed, input logic [3:0] ec);
        mk = '{v, d, r, fl, clr, ev, erdy, ed, ec};
    endfunction

    // Skid-stage scoreboard: words enter on accept, leave in order on downstream accept.
    always @(negedge clock) begin
        if (!rst) begin
            sq.delete();
        end else begin
            if (s_ovalid) begin
                if (sq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL skid_sb: unexpected word %h, expected none", s_odata);
                end else begin
                    chk("skid_sb_data", s_odata, sq[0]);
                    if (s_iready) void'(sq.pop_front());
                end
            end else begin
                chk("skid_nop_data", s_odata, 32'h0);
            end
            if (s_flush) sq.delete();
            else if (s_valid && s_ready_o) sq.push_back(s_idata);
        end
    end

    // Single-register-stage scoreboard.
    always @(negedge clock) begin
        if (!rst) begin
            nq.delete();
        end else begin
            if (n_ovalid) begin
                if (nq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL noskid_sb: unexpected word %h, expected none", n_odata);
                end else begin
                    chk("noskid_sb_data", n_odata, nq[0]);
                    if (n_iready) void'(nq.pop_front());
                end
            end else begin
                chk("noskid_nop_data", n_odata, 32'h0);
            end
            if (n_flush) nq.delete();
            else if (n_valid && n_ready_o) nq.push_back(n_idata);
        end
    end

    initial begin
        //          v     d            r     fl    clr   ev    erdy  ed           ec
        vecs[0]  = mk(1'b1, 32'h1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1,  4'd0);
        vecs[1]  = mk(1'b1, 32'h2,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2,  4'd0);
        vecs[2]  = mk(1'b1, 32'h3,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3,  4'd0);
        vecs[3]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  4'd0);
        vecs[4]  = mk(1'b1, 32'hA,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA,  4'd0);
        vecs[5]  = mk(1'b1, 32'hB,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA,  4'd1);
        vecs[6]  = mk(1'b1, 32'h77, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA,  4'd2);
        vecs[7]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA,  4'd3);
        vecs[8]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hB,  4'd3);
        vecs[9]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  4'd3);
        vecs[10] = mk(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 4'd3);
        vecs[11] = mk(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 4'd4);
        vecs[12] = mk(1'b1, 32'hC,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  4'd5);
        vecs[13] = mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  4'd5);
        vecs[14] = mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  4'd0);
        vecs[15] = mk(1'b1, 32'h21, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h21, 4'd0);
        vecs[16] = mk(1'b1, 32'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  4'd0);
        vecs[17] = mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  4'd0);

        s_valid = 1'b1; s_idata = 32'hDEAD_BEEF; s_iready = 1'b1; s_flush = 1'b0; s_clr = 1'b0;
        n_valid = 1'b1; n_idata = 32'hDEAD_BEEF; n_iready = 1'b1; n_flush = 1'b0; n_clr = 1'b0;

        // Reset held with a valid word offered.
        step();
        step();
        chk("rst_valid", {31'd0, s_ovalid}, 32'd0);
        chk("rst_data",  s_odata, 32'h0);
        chk("rst_ready", {31'd0, s_ready_o}, 32'd1);
        chk("rst_cnt",   {28'd0, s_cnt}, 32'd0);
        chk("rst_n_valid", {31'd0, n_ovalid}, 32'd0);
        s_valid = 1'b0; s_idata = 32'h0;
        n_valid = 1'b0; n_idata = 32'h0;
        rst = 1'b1;
        step();

        // Streaming, back-pressure, flush in FULL, flush with an out transfer.
        for (int i = 0; i < 18; i++) begin
            s_valid = vecs[i].v; s_idata = vecs[i].d; s_iready = vecs[i].r;
            s_flush = vecs[i].fl; s_clr = vecs[i].clr;
            step();
            chk($sformatf("vec%0d_valid", i), {31'd0, s_ovalid}, {31'd0, vecs[i].ev});
            chk($sformatf("vec%0d_ready", i), {31'd0, s_ready_o}, {31'd0, vecs[i].erdy});
            chk($sformatf("vec%0d_data", i), s_odata, vecs[i].ed);
            chk($sformatf("vec%0d_cnt", i), {28'd0, s_cnt}, {28'd0, vecs[i].ec});
        end
        s_valid = 1'b0; s_flush = 1'b0; s_clr = 1'b0;

        // Counter saturation and clear while still stalled.
        s_valid = 1'b1; s_idata = 32'h55; s_iready = 1'b0;
        step();
        s_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("sat_cnt", {28'd0, s_cnt}, 32'd15);
        chk("sat_data", s_odata, 32'h55);
        s_clr = 1'b1;
        step();
        chk("clr_cnt", {28'd0, s_cnt}, 32'd0);
        s_clr = 1'b0;
        step();
        chk("clr_recount", {28'd0, s_cnt}, 32'd1);
        s_iready = 1'b1;
        step();
        chk("drain_valid", {31'd0, s_ovalid}, 32'd0);
        chk("drain_cnt", {28'd0, s_cnt}, 32'd1);

        // Reset in the middle of a full stage.
        s_valid = 1'b1; s_idata = 32'h61; s_iready = 1'b0;
        step();
        s_idata = 32'h62;
        step();
        chk("pre_rst_ready", {31'd0, s_ready_o}, 32'd0);
        s_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, s_ovalid}, 32'd0);
        chk("midrst_ready", {31'd0, s_ready_o}, 32'd1);
        chk("midrst_data", s_odata, 32'h0);
        chk("midrst_cnt", {28'd0, s_cnt}, 32'd0);
        step();
        rst = 1'b1; s_iready = 1'b1;
        step();
        chk("postrst_valid", {31'd0, s_ovalid}, 32'd0);

        // Single-register variant: combinational ready, pass-through, flush.
        n_valid = 1'b1; n_idata = 32'h30; n_iready = 1'b0;
        step();
        n_valid = 1'b0;
        chk("ns_hold_ready", {31'd0, n_ready_o}, 32'd0);
        chk("ns_hold_data", n_odata, 32'h30);
        step();
        chk("ns_cnt", {16'd0, n_cnt}, 32'd1);
        n_iready = 1'b1;
        #1;
        chk("ns_comb_ready", {31'd0, n_ready_o}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            n_valid = 1'b1; n_idata = 32'h30 + i;
            step();
            chk($sformatf("ns_stream%0d_data", i), n_odata, 32'h30 + i);
            chk($sformatf("ns_stream%0d_ready", i), {31'd0, n_ready_o}, 32'd1);
        end
        n_valid = 1'b0;
        step();
        chk("ns_empty_valid", {31'd0, n_ovalid}, 32'd0);
        n_valid = 1'b1; n_idata = 32'h40;
        step();
        n_idata = 32'h41; n_flush = 1'b1;
        step();
        n_valid = 1'b0; n_flush = 1'b0;
        chk("ns_flush_valid", {31'd0, n_ovalid}, 32'd0);
        chk("ns_flush_data", n_odata, 32'h0);
        step();
        step();

        chk("skid_sb_drained", sq.size(), 32'd0);
        chk("noskid_sb_drained", nq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
